// File: rtl/uart_tx_arb.sv
// Round-robin sequencer that shares one uart_tx among N_REQ byte sources,
// with multi-byte message locking and a start-to-done watchdog.
module uart_tx_arb #(
    parameter int N_REQ        = 4,
    parameter int TIMEOUT_CLKS = 5000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_byte,
    input  logic [N_REQ-1:0]     i_last,
    output logic [N_REQ-1:0]     o_ack,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_tx_byte_rdy,
    output logic [7:0]           o_tx_byte,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    output logic                 o_busy,
    output logic                 o_timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W:0]   N_VAL    = (IDX_W + 1)'(N_REQ);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_pulse;

    logic [7:0]         req_byte [N_REQ];
    logic [IDX_W-1:0]   cand_idx [N_REQ];
    logic [N_REQ-1:0]   cand_ok;
    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   owner_mask;
    logic               owner_req;
    logic               lock_live;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;

    genvar gi;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_byte
            assign req_byte[gi] = i_byte[8*gi +: 8];
        end
    endgenerate

    // A lock only restricts eligibility while its owner keeps requesting;
    // a dropped owner request falls back to full arbitration in the same cycle.
    assign owner_mask = ONE_HOT0 << owner_q;
    assign owner_req  = i_req[owner_q];
    assign lock_live  = lock_q & owner_req;
    assign elig       = lock_live ? (i_req & owner_mask) : i_req;

    // Candidate gi is the requester gi+1 positions after the last winner.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IDX_W:0] raw;
            assign raw          = {1'b0, last_q} + (IDX_W + 1)'(gi + 1);
            assign cand_idx[gi] = (raw >= N_VAL) ? IDX_W'(raw - N_VAL) : raw[IDX_W-1:0];
            assign cand_ok[gi]  = elig[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_idx   = cand_idx[0];
        win_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_ok[i]) begin
                win_idx   = cand_idx[i];
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        lock_d        = lock_q;
        owner_d       = owner_q;
        last_d        = last_q;
        grant_d       = grant_q;
        tx_byte_d     = tx_byte_q;
        cnt_d         = cnt_q;
        timeout_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lock_q && !owner_req) begin
                    lock_d  = 1'b0;
                    grant_d = '0;
                end
                if (!i_tx_busy && win_found) begin
                    tx_byte_d = req_byte[win_idx];
                    grant_d   = ONE_HOT0 << win_idx;
                    owner_d   = win_idx;
                    lock_d    = ~i_last[win_idx];
                    last_d    = win_idx;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A done pulse in the final watchdog cycle still counts as success.
                if (i_tx_done) begin
                    state_d = ST_IDLE;
                    if (!lock_q) begin
                        grant_d = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_pulse = 1'b1;
                    lock_d        = 1'b0;
                    grant_d       = '0;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            lock_q    <= 1'b0;
            owner_q   <= '0;
            last_q    <= IDX_LAST;
            grant_q   <= '0;
            tx_byte_q <= 8'h00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            tx_byte_q <= tx_byte_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_tx_byte_rdy = (state_q == ST_START);
    assign o_ack         = (state_q == ST_START) ? grant_q : '0;
    assign o_grant       = grant_q;
    assign o_tx_byte     = tx_byte_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_timeout     = timeout_pulse;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester mailboxes, a uart_tx stub and a message-level
// round-robin reference model that predicts the order of transmitted bytes.
module tb_uart_tx_arb;

    localparam int N   = 4;
    localparam int TMO = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] bytes = '0;
    logic [N-1:0]   last = '0;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [N-1:0]   o_ack;
    logic [N-1:0]   o_grant;
    logic           o_tx_byte_rdy;
    logic [7:0]     o_tx_byte;
    logic           o_busy;
    logic           o_timeout;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N_REQ        (N),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_byte        (bytes),
        .i_last        (last),
        .o_ack         (o_ack),
        .o_grant       (o_grant),
        .o_tx_byte_rdy (o_tx_byte_rdy),
        .o_tx_byte     (o_tx_byte),
        .i_tx_busy     (tx_busy),
        .i_tx_done     (tx_done),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Per-requester mailbox of bytes still to be offered.
    logic [7:0] mb [N][32];
    bit         ml [N][32];
    int         hd [N];
    int         tl [N];
    bit         pop_pend [N];

    // Reference model state: expected strobe sequence.
    logic [7:0] exp_b [$];
    int         exp_r [$];
    int         rr_last   = N - 1;
    int         cur_owner = 0;

    // uart_tx stub state.
    bit strobe_pend = 0;
    bit stub_on     = 0;
    bit stub_kill   = 0;
    bit never_done  = 0;
    bit hold_busy   = 0;
    int stub_left   = 0;
    int post_left   = 0;
    int post_cfg    = 0;
    int fixed_dly   = 0;

    bit tmo_allowed = 0;
    bit gap_en      = 0;
    bit pend_gap    = 0;
    bit busy_prev   = 0;
    int done_cyc    = 0;
    int cyc         = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic load(input int k, input logic [7:0] b, input bit l);
        mb[k][tl[k]] = b;
        ml[k][tl[k]] = l;
        tl[k]++;
    endtask

    // Serve whole messages, picking the next requester with data after the last one.
    task automatic predict();
        int  mh [N];
        int  k;
        bit  l;
        for (int i = 0; i < N; i++) mh[i] = hd[i];
        for (int guard = 0; guard < 64; guard++) begin
            k = -1;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (rr_last + i) % N;
                if (k < 0 && mh[c] < tl[c]) k = c;
            end
            if (k < 0) break;
            do begin
                exp_b.push_back(mb[k][mh[k]]);
                exp_r.push_back(k);
                l = ml[k][mh[k]];
                mh[k]++;
            end while (!l && mh[k] < tl[k]);
            rr_last = k;
        end
    endtask

    function automatic bit idle_all();
        bit r;
        r = (exp_b.size() == 0) && !o_busy && !tx_busy;
        for (int k = 0; k < N; k++) if (hd[k] < tl[k]) r = 0;
        return r;
    endfunction

    task automatic drain(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = idle_all();
        end
        check_eq(tag, ok, 1);
        exp_b.delete();
        exp_r.delete();
        for (int k = 0; k < N; k++) begin
            hd[k] = 0;
            tl[k] = 0;
        end
    endtask

    task automatic wait_strobe(input string tag);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!o_tx_byte_rdy && i < 100);
        check_eq(tag, o_tx_byte_rdy, 1);
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_grant"}, o_grant, 0);
        check_eq({pfx, "_ack"}, o_ack, 0);
        check_eq({pfx, "_rdy"}, o_tx_byte_rdy, 0);
        check_eq({pfx, "_byte"}, o_tx_byte, 8'h00);
        check_eq({pfx, "_busy"}, o_busy, 0);
        check_eq({pfx, "_tmo"}, o_timeout, 0);
    endtask

    // Requester driver, uart_tx stub and output monitor.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int k = 0; k < N; k++) begin
                int ix;
                if (pop_pend[k]) begin
                    hd[k]++;
                    pop_pend[k] = 0;
                end
                ix = (hd[k] < tl[k]) ? hd[k] : 0;
                req[k]          = (hd[k] < tl[k]);
                bytes[8*k +: 8] = mb[k][ix];
                last[k]         = ml[k][ix];
            end
            tx_done = 1'b0;
            if (stub_kill) begin
                stub_on   = 0;
                post_left = 0;
                stub_kill = 0;
            end
            if (strobe_pend) begin
                strobe_pend = 0;
                stub_on     = 1;
                stub_left   = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(2, 15));
            end else if (stub_on) begin
                if (stub_left > 1) begin
                    stub_left--;
                end else if (!never_done) begin
                    tx_done   = 1'b1;
                    stub_on   = 0;
                    post_left = post_cfg;
                end
            end else if (post_left > 0) begin
                post_left--;
            end
            tx_busy = stub_on || tx_done || (post_left > 0) || hold_busy;

            @(negedge clk);
            if (o_tx_byte_rdy) begin
                strobe_pend = 1;
                check_eq("start_while_busy", busy_prev, 0);
                if (exp_b.size() == 0) begin
                    check_eq("extra_strobe", o_tx_byte_rdy, 0);
                end else begin
                    logic [7:0] eb;
                    int         er;
                    eb = exp_b.pop_front();
                    er = exp_r.pop_front();
                    $display("tx req=%0d byte=%02h cyc=%0d", er, o_tx_byte, cyc);
                    check_eq("tx_byte", o_tx_byte, eb);
                    check_eq("ack_bit", o_ack, 1 << er);
                    check_eq("grant_at_start", o_grant, 1 << er);
                    cur_owner = er;
                end
                if (pend_gap) begin
                    check_eq("b2b_gap", cyc - done_cyc, 2);
                    pend_gap = 0;
                end
                for (int k = 0; k < N; k++) if (o_ack[k]) pop_pend[k] = 1;
            end else begin
                if (o_ack != 0) check_eq("ack_no_strobe", o_ack, 0);
                if (o_busy) check_eq("grant_hold", o_grant, 1 << cur_owner);
            end
            if (o_timeout && !tmo_allowed) check_eq("unexp_timeout", o_timeout, 0);
            if (tx_done && o_busy) begin
                done_cyc = cyc;
                pend_gap = gap_en && (exp_b.size() > 0);
            end
            busy_prev = tx_busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;

        // Single byte with one-cycle latency
        load(0, 8'hA5, 1);
        predict();
        @(negedge clk);
        check_eq("lat_t0_ack", o_ack, 0);
        @(negedge clk);
        check_eq("lat_t1_rdy", o_tx_byte_rdy, 1);
        check_eq("lat_t1_ack", o_ack, 4'b0001);
        check_eq("lat_t1_byte", o_tx_byte, 8'hA5);
        @(negedge clk);
        check_eq("single_grant", o_grant, 4'b0001);
        drain("drain_single");
        check_eq("grant_idle", o_grant, 0);

        // Round robin, then requester 0 ahead of a pending requester 1
        for (int k = 0; k < N; k++) load(k, 8'h10 + 8'(k), 1);
        predict();
        drain("drain_rr");
        load(1, 8'h11, 1);
        load(0, 8'h10, 1);
        predict();
        drain("drain_rr2");

        // Locked three-byte message against a competing requester
        load(0, 8'h01, 0);
        load(0, 8'h02, 0);
        load(0, 8'h03, 1);
        load(1, 8'hFF, 1);
        predict();
        drain("drain_lock");

        // Owner drops its request mid-message; pending requester 2 goes next
        load(0, 8'h01, 0);
        exp_b.push_back(8'h01);
        exp_r.push_back(0);
        rr_last = 0;
        wait_strobe("drop_strobe");
        load(2, 8'hB2, 1);
        exp_b.push_back(8'hB2);
        exp_r.push_back(2);
        rr_last = 2;
        drain("drain_drop");

        // Randomized phases
        for (int ph = 0; ph < 40; ph++) begin
            post_cfg = $urandom_range(0, 2);
            gap_en   = (post_cfg == 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int nm;
                    nm = $urandom_range(1, 2);
                    for (int m = 0; m < nm; m++) begin
                        int len;
                        len = $urandom_range(1, 3);
                        for (int b = 0; b < len; b++) load(k, 8'($urandom), (b == len - 1));
                    end
                end
            end
            predict();
            drain("drain_rand");
        end
        gap_en   = 0;
        post_cfg = 0;

        // Watchdog abort on a locked message; lock must be dropped
        never_done  = 1;
        tmo_allowed = 1;
        load(0, 8'hC0, 0);
        load(0, 8'hC1, 1);
        exp_b.push_back(8'hC0);
        exp_r.push_back(0);
        rr_last = 0;
        wait_strobe("tmo_strobe");
        load(2, 8'hD2, 1);
        repeat (19) @(negedge clk);
        check_eq("tmo_early", o_timeout, 0);
        @(negedge clk);
        check_eq("tmo_pulse", o_timeout, 1);
        @(negedge clk);
        check_eq("tmo_grant", o_grant, 0);
        check_eq("tmo_busy", o_busy, 0);
        check_eq("tmo_once", o_timeout, 0);
        stub_kill   = 1;
        never_done  = 0;
        tmo_allowed = 0;
        predict();
        drain("drain_tmo");

        // Reset in WAIT_DONE while uart_tx is still busy
        fixed_dly = 15;
        load(2, 8'h33, 1);
        predict();
        wait_strobe("mrst_strobe");
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        hold_busy = 1;
        stub_kill = 1;
        @(negedge clk);
        check_zero("mrst");
        rst       = 1'b0;
        fixed_dly = 0;
        rr_last   = N - 1;
        load(1, 8'h44, 1);
        load(0, 8'h55, 1);
        predict();
        repeat (4) begin
            @(negedge clk);
            check_eq("mrst_no_start", o_tx_byte_rdy, 0);
        end
        hold_busy = 0;
        drain("drain_mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter/sequencer sharing one `uart_tx` among `N_REQ` byte sources. It accepts bytes from requesters over a req/ack handshake, issues one-cycle start strobes to `uart_tx`, and waits for its done pulse before the next byte. It supports multi-byte message locking and a done-timeout watchdog. It sits between firmware-side byte producers and the `uart_tx` instance at the top level, with `CLKS_PER_BIT` = 434.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CLKS`, 5000: max clocks from start strobe to `i_tx_done` before abort (≥ 10*`CLKS_PER_BIT`+2).
- `i_clk` in 1: single clock. Everything is clocked on the rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_req` in `N_REQ`: per-requester byte-valid. Held until the matching `o_ack`.
- `i_byte` in 8*`N_REQ`: requester k's byte is in bits [8k+7:8k]. Must be stable while `i_req[k]` is high.
- `i_last` in `N_REQ`: qualifies `i_byte[k]`. 1 = final byte of a message; 0 = keep the lock.
- `o_ack` out `N_REQ`: one-cycle pulse when requester k's byte is accepted.
- `o_grant` out `N_REQ`: one-hot current owner. 0 when no owner.
- `o_tx_byte_rdy` out 1: one-cycle start strobe to `uart_tx`.
- `o_tx_byte` out 8: byte to `uart_tx`. Valid with the strobe and held until the next strobe.
- `i_tx_busy` in 1: from `uart_tx`.
- `i_tx_done` in 1: one-cycle pulse from `uart_tx` at the end of the stop bit.
- `o_busy` out 1: high in any state other than IDLE.
- `o_timeout` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, START, WAIT_DONE.
- **IDLE:**
  - No start is issued while `i_tx_busy`=1.
  - Eligible set = the lock owner only, if a lock is held. Otherwise it is all of `i_req`.
  - If the lock owner's `i_req` is low in IDLE, the lock is released and full arbitration runs in the same cycle.
  - Round-robin search begins at (last_granted+1) mod `N_REQ`. `last_granted` resets to `N_REQ`-1, so requester 0 wins first.
  - On a winner k: latch `i_byte[k]`, set `o_grant`=onehot(k), set lock = ~`i_last[k]`, update last_granted=k, and go to START.
- **START** (exactly 1 cycle):
  - `o_tx_byte_rdy`=1 and `o_ack[k]`=1.
  - Clear the watchdog counter, then go to WAIT_DONE.
- **WAIT_DONE:**
  - The counter increments each cycle.
  - `i_tx_done`=1 → go to IDLE.
  - Counter reaches `TIMEOUT_CLKS`-1 without done → pulse `o_timeout`, clear lock and `o_grant`, and go to IDLE.
  - If done and timeout occur in the same cycle, done wins and there is no timeout pulse.
- `o_grant` holds k through WAIT_DONE. It stays at k while the lock is held. It clears on entry to IDLE when unlocked.
- `i_tx_done` outside WAIT_DONE is ignored.
- Counter width is $clog2(`TIMEOUT_CLKS`) and it never wraps.
- Requests arriving mid-message from non-owners wait. They are not dropped.

## Timing
- Reset values: state IDLE, all outputs 0, `o_tx_byte`=8'h00, lock clear, last_granted=`N_REQ`-1.
- Reset during WAIT_DONE: abort immediately. No ack or timeout is generated.
- Latency: `i_req` high in IDLE at cycle t → `o_ack` and `o_tx_byte_rdy` at t+1.
- Back-to-back: `i_tx_done` at cycle d → IDLE at d+1 → next strobe at d+2.
- Per-byte overhead beyond `uart_tx` is 2 clocks.
- The requester may change `i_byte` and `i_last` the cycle after `o_ack`. The arbiter next samples them in IDLE.
- At most one `o_ack` bit is high in any cycle. `o_ack` and `o_tx_byte_rdy` are always coincident.

## Test plan
- **Single byte:**
  - Stimulus: after reset, `i_req`=4'b0001, byte 8'hA5, `i_last`=1.
  - Response: ack[0] and strobe 1 cycle later with `o_tx_byte`=8'hA5; `o_grant`=0001 until done; with `uart_tx` in loopback, `uart_rx` returns 8'hA5.
- **Round robin:**
  - Stimulus: all four requesters hold single-byte messages 8'h10/11/12/13.
  - Response: strobes in order 10,11,12,13. Then 10 again if req[0] is re-raised while req[1] is also pending, with 11 following.
- **Lock:**
  - Stimulus: req0 sends 3 bytes 8'h01,02,03 (`i_last` only on 03) while req1 continuously requests 8'hFF.
  - Response: 01,02,03 go out contiguously, then FF.
- **Lock release on drop:**
  - Stimulus: req0 sends 8'h01 with `i_last`=0, then deasserts; req2 is pending.
  - Response: after done, the next strobe carries req2's byte.
- **Timeout:**
  - Stimulus: stub `uart_tx` never pulses done, with `TIMEOUT_CLKS`=20.
  - Response: `o_timeout` pulses 20 cycles after the strobe cycle; `o_grant`=0; next request is serviced.
- **Reset mid-transfer:**
  - Stimulus: assert `i_rst` for 1 cycle during WAIT_DONE.
  - Response: all outputs 0 the next cycle; no strobe while `i_tx_busy`=1; first grant after reset goes to requester 0.
